uart_tx_scheduler: RTL and testbench

//  Round-robin scheduler sharing one UART transmitter between N_REQ byte requesters.

---
 rtl/uart_tx_scheduler_pkg.sv | 24 ++
 rtl/uart_tx_scheduler_rr_arbiter.sv | 39 +++
 rtl/uart_tx_scheduler.sv | 140 ++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_scheduler_pkg.sv
// Shared definitions for the UART transmit scheduler.
//  - sched_state_e : 3-bit FSM state encoding
//  - PAR_EVEN/ODD  : parity type encoding on the CFG_PAR_TYP / TX_PAR_TYP lines
//  - max_int       : elaboration-time helper for sizing counters
package uart_tx_scheduler_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_LAUNCH    = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GAP       = 3'd4
  } sched_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//  req_i     : request vector, one bit per requester
//  ptr_i     : index of the highest-priority requester this round
//  gnt_o     : one-hot grant (all zero when no request)
//  gnt_idx_o : index of the granted requester (0 when no request)
//  gnt_any_o : at least one request present
module uart_rr_arbiter
  import uart_tx_scheduler_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req_i,
  input  logic [$clog2(N_REQ)-1:0] ptr_i,
  output logic [N_REQ-1:0]         gnt_o,
  output logic [$clog2(N_REQ)-1:0] gnt_idx_o,
  output logic                     gnt_any_o
);

  localparam int IDX_W = $clog2(N_REQ);

  // Walk upward from the pointer, wrapping; the first set bit wins.
  always_comb begin
    int idx;
    idx       = 0;
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_any_o = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(ptr_i) + i) % N_REQ;
      if (!gnt_any_o && req_i[idx]) begin
        gnt_any_o  = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among N_REQ byte sources.
// Ports:
//  clk_i, rst_i        : clock (rising edge), asynchronous active-high reset
//  req_valid_i         : per-requester byte pending, held until its ack
//  req_data_i          : requester i byte at [8*i+7:8*i]
//  cfg_par_en_i/typ_i  : per-requester parity enable / type (0 even, 1 odd)
//  req_ack_o           : one-hot, one-cycle pulse when a byte is captured
//  tx_busy_i           : transmitter busy
//  tx_data_valid_o     : one-cycle launch pulse to the transmitter
//  tx_p_data_o         : captured byte; tx_par_en_o / tx_par_typ_o its parity cfg
//  grant_id_o          : index of the current/last granted requester
//  sched_busy_o        : high in every state except IDLE
//  to_err_o            : one-cycle pulse when TX never went busy after a launch
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int BUSY_TO = 8,
  parameter int GAP_CYC = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_REQ-1:0]         req_valid_i,
  input  logic [8*N_REQ-1:0]       req_data_i,
  input  logic [N_REQ-1:0]         cfg_par_en_i,
  input  logic [N_REQ-1:0]         cfg_par_typ_i,
  output logic [N_REQ-1:0]         req_ack_o,
  input  logic                     tx_busy_i,
  output logic                     tx_data_valid_o,
  output logic [7:0]               tx_p_data_o,
  output logic                     tx_par_en_o,
  output logic                     tx_par_typ_o,
  output logic [$clog2(N_REQ)-1:0] grant_id_o,
  output logic                     sched_busy_o,
  output logic                     to_err_o
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(max_int(BUSY_TO, GAP_CYC) + 1);
  // Timeout fires on the edge where the counter would reach BUSY_TO-1,
  // which places TO_ERR exactly BUSY_TO cycles after the launch pulse.
  localparam logic [CNT_W-1:0] BUSY_LAST = CNT_W'(BUSY_TO - 2);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);

  sched_state_e      state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [IDX_W-1:0]  ptr_q;
  logic [IDX_W-1:0]  grant_q;
  logic [N_REQ-1:0]  ack_q;
  logic              dv_q;
  logic [7:0]        data_q;
  logic              par_en_q;
  logic              par_typ_q;
  logic              to_err_q;

  logic [N_REQ-1:0]  gnt;
  logic [IDX_W-1:0]  gnt_idx;
  logic              gnt_any;
  logic [IDX_W-1:0]  ptr_d;

  uart_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req_i     (req_valid_i),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .gnt_any_o (gnt_any)
  );

  // Explicit wrap so non-power-of-two N_REQ works.
  assign ptr_d = (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ptr_q     <= '0;
      grant_q   <= '0;
      ack_q     <= '0;
      dv_q      <= 1'b0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      to_err_q  <= 1'b0;
    end else begin
      ack_q    <= '0;
      dv_q     <= 1'b0;
      to_err_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          // A foreign frame on the line (tx busy while idle) blocks arbitration.
          if (!tx_busy_i && gnt_any) begin
            data_q    <= req_data_i[8*gnt_idx +: 8];
            par_en_q  <= cfg_par_en_i[gnt_idx];
            par_typ_q <= cfg_par_typ_i[gnt_idx];
            grant_q   <= gnt_idx;
            ptr_q     <= ptr_d;
            ack_q     <= gnt;
            dv_q      <= 1'b1;
            state_q   <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          cnt_q   <= '0;
          state_q <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (tx_busy_i) begin
            state_q <= ST_WAIT_DONE;
          end else if (cnt_q == BUSY_LAST) begin
            to_err_q <= 1'b1;
            state_q  <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (!tx_busy_i) begin
            cnt_q   <= '0;
            state_q <= (GAP_CYC > 0) ? ST_GAP : ST_IDLE;
          end
        end
        ST_GAP: begin
          if (cnt_q == GAP_LAST) state_q <= ST_IDLE;
          else                   cnt_q   <= cnt_q + CNT_W'(1);
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ack_o       = ack_q;
  assign tx_data_valid_o = dv_q;
  assign tx_p_data_o     = data_q;
  assign tx_par_en_o     = par_en_q;
  assign tx_par_typ_o    = par_typ_q;
  assign grant_id_o      = grant_q;
  assign sched_busy_o    = (state_q != ST_IDLE);
  assign to_err_o        = to_err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed self-checking bench for uart_tx_scheduler (N_REQ=4, BUSY_TO=8, GAP_CYC=2).
module tb_uart_tx_scheduler;

  localparam int N_REQ   = 4;
  localparam int BUSY_TO = 8;
  localparam int GAP_CYC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  cfg_par_en;
  logic [3:0]  cfg_par_typ;
  logic [3:0]  req_ack;
  logic        tx_busy;
  logic        tx_data_valid;
  logic [7:0]  tx_p_data;
  logic        tx_par_en;
  logic        tx_par_typ;
  logic [1:0]  grant_id;
  logic        sched_busy;
  logic        to_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx_scheduler #(.N_REQ(N_REQ), .BUSY_TO(BUSY_TO), .GAP_CYC(GAP_CYC)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .req_valid_i     (req_valid),
    .req_data_i      (req_data),
    .cfg_par_en_i    (cfg_par_en),
    .cfg_par_typ_i   (cfg_par_typ),
    .req_ack_o       (req_ack),
    .tx_busy_i       (tx_busy),
    .tx_data_valid_o (tx_data_valid),
    .tx_p_data_o     (tx_p_data),
    .tx_par_en_o     (tx_par_en),
    .tx_par_typ_o    (tx_par_typ),
    .grant_id_o      (grant_id),
    .sched_busy_o    (sched_busy),
    .to_err_o        (to_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // sel 0: launch pulse, 1: timeout pulse, 2: scheduler idle. n = negedges waited.
  task automatic wait_until(input int sel, input int limit, output int n);
    n = 0;
    while (n < limit) begin
      @(negedge clk);
      n++;
      if (sel == 0 && tx_data_valid === 1'b1) break;
      if (sel == 1 && to_err === 1'b1) break;
      if (sel == 2 && sched_busy === 1'b0) break;
    end
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    req_valid = '0;
    tx_busy = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  // Called on the launch negedge: transmitter busy for blen cycles, then idle.
  task automatic finish_frame(input int blen);
    int n;
    tx_busy = 1'b1;
    repeat (blen) tick();
    tx_busy = 1'b0;
    wait_until(2, 20, n);
    check_eq("busy fall to idle", 32'(n), 32'(GAP_CYC + 1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, " ack"},   32'(req_ack), 32'h0);
    check_eq({tag, " dv"},    32'(tx_data_valid), 32'h0);
    check_eq({tag, " data"},  32'(tx_p_data), 32'h0);
    check_eq({tag, " paren"}, 32'(tx_par_en), 32'h0);
    check_eq({tag, " partyp"},32'(tx_par_typ), 32'h0);
    check_eq({tag, " grant"}, 32'(grant_id), 32'h0);
    check_eq({tag, " sbusy"}, 32'(sched_busy), 32'h0);
    check_eq({tag, " toerr"}, 32'(to_err), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    req_valid = '0;
    req_data = 32'h13121110;
    cfg_par_en = '0;
    cfg_par_typ = '0;
    tx_busy = 1'b0;
    #1;
    check_reset_outputs("por");
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Single request from requester 2 with odd parity.
    req_data = 32'h13A51110;
    cfg_par_en = 4'b0100;
    cfg_par_typ = 4'b0100;
    req_valid = 4'b0100;
    tick();
    check_eq("t1 dv", 32'(tx_data_valid), 32'h1);
    check_eq("t1 ack", 32'(req_ack), 32'h4);
    check_eq("t1 data", 32'(tx_p_data), 32'hA5);
    check_eq("t1 paren", 32'(tx_par_en), 32'h1);
    check_eq("t1 partyp", 32'(tx_par_typ), 32'h1);
    check_eq("t1 grant", 32'(grant_id), 32'h2);
    check_eq("t1 sbusy", 32'(sched_busy), 32'h1);
    req_valid = '0;
    tick();
    check_eq("t1 dv pulse", 32'(tx_data_valid), 32'h0);
    check_eq("t1 ack pulse", 32'(req_ack), 32'h0);
    check_eq("t1 data held", 32'(tx_p_data), 32'hA5);
    finish_frame(3);
    check_eq("t1 data after", 32'(tx_p_data), 32'hA5);
    cfg_par_en = '0;
    cfg_par_typ = '0;
    req_data = 32'h13121110;

    // All four requesting continuously; transmitter busy 11 cycles per frame.
    do_reset();
    req_valid = 4'hF;
    for (int f = 0; f < 5; f++) begin
      wait_until(0, 40, n);
      if (f == 0) check_eq("rr first latency", 32'(n), 32'h1);
      else        check_eq("rr fall to launch", 32'(n), 32'(GAP_CYC + 2));
      check_eq("rr grant", 32'(grant_id), 32'(f % 4));
      check_eq("rr data", 32'(tx_p_data), 32'(8'h10 + f % 4));
      check_eq("rr ack", 32'(req_ack), 32'(1 << (f % 4)));
      if (f == 4) req_valid = '0;
      tx_busy = 1'b1;
      repeat (11) tick();
      tx_busy = 1'b0;
    end
    wait_until(2, 20, n);
    check_eq("rr final idle", 32'(n), 32'(GAP_CYC + 1));

    // Transmitter never goes busy: timeout, then normal service.
    do_reset();
    req_valid = 4'b0001;
    tick();
    check_eq("to launch", 32'(tx_data_valid), 32'h1);
    req_valid = '0;
    wait_until(1, 30, n);
    check_eq("to delay", 32'(n), 32'(BUSY_TO));
    check_eq("to sbusy", 32'(sched_busy), 32'h0);
    tick();
    check_eq("to pulse", 32'(to_err), 32'h0);
    req_valid = 4'b0010;
    tick();
    check_eq("to next dv", 32'(tx_data_valid), 32'h1);
    check_eq("to next grant", 32'(grant_id), 32'h1);
    check_eq("to next data", 32'(tx_p_data), 32'h11);
    req_valid = '0;
    finish_frame(4);

    // Reset in WAIT_DONE, released with requester 1 pending.
    do_reset();
    req_valid = 4'b0001;
    tick();
    check_eq("rst launch", 32'(tx_data_valid), 32'h1);
    req_valid = '0;
    tx_busy = 1'b1;
    repeat (2) tick();
    rst = 1'b1;
    tx_busy = 1'b0;
    req_valid = 4'b0010;
    #1;
    check_reset_outputs("mid");
    repeat (2) begin
      tick();
      check_eq("rst hold dv", 32'(tx_data_valid), 32'h0);
    end
    rst = 1'b0;
    tick();
    check_eq("rst rel dv", 32'(tx_data_valid), 32'h1);
    check_eq("rst rel grant", 32'(grant_id), 32'h1);
    check_eq("rst rel ack", 32'(req_ack), 32'h2);
    req_valid = '0;
    finish_frame(3);

    // Requester 3 pulses for one cycle during the gap, then withdraws.
    do_reset();
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    tx_busy = 1'b1;
    repeat (3) tick();
    tx_busy = 1'b0;
    tick();
    check_eq("gap state busy", 32'(sched_busy), 32'h1);
    req_valid = 4'b1000;
    tick();
    req_valid = '0;
    repeat (6) begin
      tick();
      check_eq("gap no dv", 32'(tx_data_valid), 32'h0);
      check_eq("gap no ack", 32'(req_ack), 32'h0);
    end
    check_eq("gap idle", 32'(sched_busy), 32'h0);

    // Foreign frame on the line while idle holds off the launch.
    do_reset();
    tx_busy = 1'b1;
    req_valid = 4'b0001;
    repeat (4) begin
      tick();
      check_eq("foreign no dv", 32'(tx_data_valid), 32'h0);
      check_eq("foreign idle", 32'(sched_busy), 32'h0);
    end
    tx_busy = 1'b0;
    tick();
    check_eq("foreign dv", 32'(tx_data_valid), 32'h1);
    check_eq("foreign ack", 32'(req_ack), 32'h1);
    req_valid = '0;
    finish_frame(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
